rect80_round_ctrl: RTL



---
 rtl/rect80_round_ctrl_if.sv | 32 +++
 rtl/rect80_round_ctrl.sv | 104 ++++++++++
 2 files changed

// File: rtl/rect80_round_ctrl_if.sv
// Handshake and strobe bundle between the RECTANGLE-80 round sequencer and its datapath/consumer.
// Optional port i_abort is present only when RECT_ABORT_EN is defined.
interface rect80_round_ctrl_if;
    logic       i_start;
    logic       o_ready;
    logic       o_load;
    logic       o_round_en;
    logic       o_final;
    logic [4:0] ov_round;
    logic [4:0] ov_rc;
    logic       o_valid;
    logic       i_out_ready;
`ifdef RECT_ABORT_EN
    logic       i_abort;
`endif

    modport master (
`ifdef RECT_ABORT_EN
        output i_abort,
`endif
        output i_start, i_out_ready,
        input  o_ready, o_load, o_round_en, o_final, ov_round, ov_rc, o_valid
    );

    modport slave (
`ifdef RECT_ABORT_EN
        input  i_abort,
`endif
        input  i_start, i_out_ready,
        output o_ready, o_load, o_round_en, o_final, ov_round, ov_rc, o_valid
    );
endinterface

// File: rtl/rect80_round_ctrl.sv
// Round sequencer for RECTANGLE-80: load/round/final strobes, round counter, round-constant LFSR.
// Define RECT_ABORT_EN to add the i_abort input that returns any active run to IDLE.
module rect80_round_ctrl #(
    parameter int unsigned NUM_ROUNDS = 25,
    parameter logic [4:0]  RC_INIT    = 5'h01
) (
    input  logic               i_clk,
    input  logic               i_rst,
    rect80_round_ctrl_if.slave bus
);
    localparam int unsigned CNT_W = 5;
    localparam logic [CNT_W-1:0] LAST_RND = CNT_W'(NUM_ROUNDS - 1);

    typedef enum logic [2:0] {
        S_IDLE  = 3'd0,
        S_LOAD  = 3'd1,
        S_ROUND = 3'd2,
        S_FINAL = 3'd3,
        S_DONE  = 3'd4
    } state_t;

    state_t           state_q, state_nxt;
    logic [CNT_W-1:0] cnt_q, cnt_nxt;
    logic [4:0]       rc_q, rc_nxt;
    logic             ready_q, load_q, round_en_q, final_q, valid_q;
    logic             ready_nxt, load_nxt, round_en_nxt, final_nxt, valid_nxt;

    // State, counter, LFSR and decoded strobes are all registered together.
    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            state_q    <= S_IDLE;
            cnt_q      <= '0;
            rc_q       <= RC_INIT;
            ready_q    <= 1'b1;
            load_q     <= 1'b0;
            round_en_q <= 1'b0;
            final_q    <= 1'b0;
            valid_q    <= 1'b0;
        end else begin
            state_q    <= state_nxt;
            cnt_q      <= cnt_nxt;
            rc_q       <= rc_nxt;
            ready_q    <= ready_nxt;
            load_q     <= load_nxt;
            round_en_q <= round_en_nxt;
            final_q    <= final_nxt;
            valid_q    <= valid_nxt;
        end
    end

    // Next state; counter is zero everywhere outside ROUND so it can drive ov_round directly.
    always_comb begin
        state_nxt = state_q;
        cnt_nxt   = cnt_q;
        rc_nxt    = rc_q;
        case (state_q)
            S_IDLE: begin
                if (bus.i_start) begin
                    state_nxt = S_LOAD;
                    cnt_nxt   = '0;
                    rc_nxt    = RC_INIT;
                end
            end
            S_LOAD:  state_nxt = S_ROUND;
            S_ROUND: begin
                rc_nxt = {rc_q[3:0], rc_q[4] ^ rc_q[2]};
                if (cnt_q == LAST_RND) begin
                    state_nxt = S_FINAL;
                    cnt_nxt   = '0;
                end else begin
                    cnt_nxt = cnt_q + CNT_W'(1);
                end
            end
            S_FINAL: state_nxt = S_DONE;
            S_DONE:  if (bus.i_out_ready) state_nxt = S_IDLE;
            default: state_nxt = S_IDLE;
        endcase
`ifdef RECT_ABORT_EN
        if (bus.i_abort && (state_q != S_IDLE)) begin
            state_nxt = S_IDLE;
            cnt_nxt   = '0;
            rc_nxt    = RC_INIT;
        end
`endif
        ready_nxt    = (state_nxt == S_IDLE);
        load_nxt     = (state_nxt == S_LOAD);
        round_en_nxt = (state_nxt == S_ROUND);
        final_nxt    = (state_nxt == S_FINAL);
        valid_nxt    = (state_nxt == S_DONE);
    end

    assign bus.o_ready    = ready_q;
    assign bus.o_load     = load_q;
    assign bus.o_round_en = round_en_q;
    assign bus.o_final    = final_q;
    assign bus.o_valid    = valid_q;
    assign bus.ov_round   = cnt_q;
    assign bus.ov_rc      = rc_q;

    a_cnt_range: assert property (@(posedge i_clk) disable iff (i_rst)
        cnt_q < CNT_W'(NUM_ROUNDS));
    a_strobe_onehot: assert property (@(posedge i_clk) disable iff (i_rst)
        $onehot0({load_q, round_en_q, final_q}));
endmodule
